// File: rtl/urng_ctrl_pkg.sv
// Shared types and helpers for the URNG sequencer/arbiter slice.
package urng_ctrl_pkg;

   typedef enum logic [1:0] {
      RESEED = 2'd0,
      WARMUP = 2'd1,
      ARB    = 2'd2
   } urng_ctrl_state_e;

   localparam int URNG_DATA_W = 64;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search begins one past the last winner.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   input  logic                       en,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

   localparam int IW = $clog2(NUM_REQ);

   logic w_found;
   int   w_idx;

   always_comb begin
      w_found = 1'b0;
      w_idx   = 0;
      gnt     = '0;
      gnt_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = (int'(last) + i) % NUM_REQ;
         if (en && !w_found && req[w_idx]) begin
            w_found    = 1'b1;
            gnt[w_idx] = 1'b1;
            gnt_idx    = w_idx[IW-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

endmodule

// File: rtl/urng_arbiter.sv
// Sequences reseed/warm-up of a shared 64-bit RNG and round-robins its samples.
// Optional per-requester grant counters: define URNG_ARBITER_STATS_EN.
module urng_arbiter
   import urng_ctrl_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WARMUP_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         reseed,
   input  logic [NUM_REQ-1:0]           req,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [URNG_DATA_W-1:0]       rsp_data,
   output logic                         ready,
   output logic                         urng_en,
   output logic                         urng_rstn,
`ifdef URNG_ARBITER_STATS_EN
   input  logic [$clog2(NUM_REQ)-1:0]   stat_sel,
   output logic [31:0]                  stat_cnt,
`endif
   input  logic                         urng_valid,
   input  logic [URNG_DATA_W-1:0]       urng_data
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int WCW = cnt_w(WARMUP_CYCLES);

   urng_ctrl_state_e r_state;
   logic [WCW-1:0]   r_wcnt;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    r_pend_idx;
   logic             r_pend_vld;

   logic               w_arb_en;
   logic               w_grant;
   logic [NUM_REQ-1:0] w_gnt;
   logic [IW-1:0]      w_gnt_idx;

   // Outputs are gated by rstn so a reset cycle aborts grants and responses at once.
   assign w_arb_en  = rstn & (r_state == ARB) & ~reseed;
   assign w_grant   = |w_gnt;
   assign gnt       = w_gnt;
   assign ready     = rstn & (r_state == ARB);
   assign urng_en   = rstn & ((r_state == WARMUP) | w_grant);
   assign urng_rstn = rstn & (r_state != RESEED);
   assign rsp_data  = urng_data;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req     (req),
      .last    (r_last),
      .en      (w_arb_en),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   always_comb begin
      rsp_valid = '0;
      if (rstn && r_pend_vld && urng_valid) begin
         rsp_valid[r_pend_idx] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= RESEED;
         r_wcnt     <= '0;
         r_last     <= IW'(NUM_REQ - 1);
         r_pend_vld <= 1'b0;
         r_pend_idx <= '0;
      end else begin
         r_pend_vld <= w_grant;
         r_pend_idx <= w_gnt_idx;
         if (w_grant) begin
            r_last <= w_gnt_idx;
         end
         case (r_state)
            RESEED: begin
               r_state <= WARMUP;
               r_wcnt  <= '0;
            end
            WARMUP: begin
               if (r_wcnt == WCW'(WARMUP_CYCLES - 1)) begin
                  r_state <= ARB;
                  r_wcnt  <= '0;
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            ARB: begin
               if (reseed) begin
                  r_state <= RESEED;
               end
            end
            default: r_state <= RESEED;
         endcase
      end
   end

`ifdef URNG_ARBITER_STATS_EN
   logic [31:0] r_stat [NUM_REQ];

   // Saturating grant counters survive reseeds; only rstn clears them.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_stat[i] <= 32'd0;
         end
         stat_cnt <= 32'd0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i] && (r_stat[i] != 32'hFFFF_FFFF)) begin
               r_stat[i] <= r_stat[i] + 32'd1;
            end
         end
         stat_cnt <= r_stat[stat_sel];
      end
   end
`endif

endmodule

// File: tb/tb_urng_arbiter.sv
// Directed bench for urng_arbiter with WARMUP_CYCLES=4 and a counting RNG model.
module tb_urng_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rstn, reseed;
   logic [N-1:0] req;
   logic [N-1:0] gnt, rsp_valid;
   logic [63:0] rsp_data;
   logic        ready, urng_en, urng_rstn, urng_valid;
   logic [63:0] urng_data;
   int          rng_cnt;
   int          n_pass = 0;
   int          n_chk  = 0;
`ifdef URNG_ARBITER_STATS_EN
   logic [1:0]  stat_sel;
   logic [31:0] stat_cnt;
`endif

   always #5 clk = ~clk;

   urng_arbiter #(.NUM_REQ(N), .WARMUP_CYCLES(W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .reseed     (reseed),
      .req        (req),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .ready      (ready),
      .urng_en    (urng_en),
      .urng_rstn  (urng_rstn),
`ifdef URNG_ARBITER_STATS_EN
      .stat_sel   (stat_sel),
      .stat_cnt   (stat_cnt),
`endif
      .urng_valid (urng_valid),
      .urng_data  (urng_data)
   );

   function automatic logic [63:0] smp(input int k);
      return {32'(k) * 32'h9E37_79B9, 32'(k) ^ 32'hC0DE_0000};
   endfunction

   // RNG core stand-in: k-th enabled cycle after its reset yields smp(k).
   always_ff @(posedge clk) begin
      if (!urng_rstn) begin
         rng_cnt    <= 0;
         urng_data  <= 64'd0;
         urng_valid <= 1'b0;
      end else begin
         urng_valid <= urng_en;
         if (urng_en) begin
            rng_cnt   <= rng_cnt + 1;
            urng_data <= smp(rng_cnt + 1);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic [N-1:0] e_gnt, input logic [N-1:0] e_rv,
                          input logic e_rdy, input logic e_en, input logic e_rst);
      chk({tag, ".gnt"}, 64'(gnt), 64'(e_gnt));
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e_rv));
      chk({tag, ".ready"}, 64'(ready), 64'(e_rdy));
      chk({tag, ".urng_en"}, 64'(urng_en), 64'(e_en));
      chk({tag, ".urng_rstn"}, 64'(urng_rstn), 64'(e_rst));
   endtask

   initial begin
      rstn = 1'b0; reseed = 1'b0; req = '0;
`ifdef URNG_ARBITER_STATS_EN
      stat_sel = 2'd0;
`endif
      for (int i = 0; i < 3; i++) cyc();
      #1;
      chk_ctl("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("reset.rsp_data", rsp_data, 64'd0);

      // Start-up: cycle 0 RESEED, cycles 1..4 WARMUP, with all requests high.
      cyc(); rstn = 1'b1; req = 4'b1111; #1;
      chk_ctl("c0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= W; c++) begin
         cyc(); #1;
         chk_ctl("warmup", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
      end

      // ARB cycles 5..12 with all requesting, then drain at 13.
      for (int c = 5; c <= 13; c++) begin
         cyc();
         req = (c <= 12) ? 4'b1111 : 4'b0000;
         #1;
         chk_ctl("rr", (c <= 12) ? 4'(1 << ((c - 5) % 4)) : 4'b0000,
                 (c >= 6) ? 4'(1 << ((c - 6) % 4)) : 4'b0000,
                 1'b1, (c <= 12), 1'b1);
         if (c >= 6) chk("rr.data", rsp_data, smp(W + c - 5));
      end
      cyc(); #1;
      chk_ctl("idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);

      // Lone requester 2 for three cycles: re-granted every cycle.
      for (int c = 0; c < 4; c++) begin
         cyc();
         req = (c < 3) ? 4'b0100 : 4'b0000;
         #1;
         chk("solo.gnt", 64'(gnt), (c < 3) ? 64'h4 : 64'h0);
         chk("solo.rv", 64'(rsp_valid), (c > 0) ? 64'h4 : 64'h0);
         if (c > 0) chk("solo.data", rsp_data, smp(W + 8 + c));
      end

      // Grant to 0, then reseed together with req[1].
      cyc(); req = 4'b0001; #1;
      chk("pre.gnt", 64'(gnt), 64'h1);
      cyc(); reseed = 1'b1; req = 4'b0010; #1;
      chk_ctl("reseed_t", 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1);
      chk("reseed_t.data", rsp_data, smp(W + 12));
      cyc(); reseed = 1'b0; #1;
      chk_ctl("reseed_t1", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < W; c++) begin
         cyc(); #1;
         chk_ctl("rewarm", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
      end
      cyc(); #1;
      chk_ctl("rearb", 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1);
      cyc(); req = 4'b0000; #1;
      chk("rearb.rv", 64'(rsp_valid), 64'h2);
      chk("rearb.data", rsp_data, smp(W + 1));

      // Grant to 2, then drop rstn the next cycle.
      cyc(); req = 4'b0100; #1;
      chk("abort.gnt", 64'(gnt), 64'h4);
      cyc(); rstn = 1'b0; req = 4'b0000; #1;
      chk_ctl("abort0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(); #1;
      chk_ctl("abort1", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("abort1.data", rsp_data, 64'd0);

      // Restart: last is back to NUM_REQ-1, so requester 0 wins first.
      cyc(); rstn = 1'b1; req = 4'b1111; #1;
      for (int c = 1; c <= W; c++) cyc();
      cyc(); #1;
      chk_ctl("restart", 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         cyc(); req = 4'b1000; #1;
         chk("g3.gnt", 64'(gnt), 64'h8);
         if (c == 0) chk("restart.data", rsp_data, smp(W + 1));
      end
      cyc(); req = 4'b0000;
`ifdef URNG_ARBITER_STATS_EN
      stat_sel = 2'd3;
`endif
      #1;
      chk("g3.last_rv", 64'(rsp_valid), 64'h8);
`ifdef URNG_ARBITER_STATS_EN
      cyc(); reseed = 1'b1; #1;
      chk("stat.cnt", 64'(stat_cnt), 64'd5);
      cyc(); reseed = 1'b0;
      cyc(); #1;
      chk("stat.keep", 64'(stat_cnt), 64'd5);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
